// File: rtl/sha1_pkg.sv
// Shared types and constants for the SHA-1 message padder.
package sha1_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    EMIT   = 2'd1,
    EMIT_X = 2'd2
  } state_t;

  localparam int unsigned BLK_WORDS  = 16;
  localparam int unsigned LEN_HI_IDX = 14;
  localparam int unsigned LEN_LO_IDX = 15;
  localparam logic [31:0] PAD_WORD   = 32'h8000_0000;

  // Keep the first nbytes (MSB-aligned) of data and put the 0x80 marker right after them.
  function automatic logic [31:0] sha1_pad_word(input logic [31:0] data, input logic [2:0] nbytes);
    logic [31:0] w;
    case (nbytes)
      3'd0:    w = PAD_WORD;
      3'd1:    w = {data[31:24], 24'h80_0000};
      3'd2:    w = {data[31:16], 16'h8000};
      3'd3:    w = {data[31:8], 8'h80};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/sha1_padder.sv
// Packs a 32-bit word stream into 512-bit blocks and appends SHA-1 padding and bit length.
module sha1_padder
  import sha1_pkg::*;
#(
  parameter int unsigned CNT_W = 61
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  input  logic         in_last_i,
  input  logic [2:0]   in_bytes_i,
  output logic         blk_valid_o,
  input  logic         blk_ready_i,
  output logic [511:0] blk_data_o,
  output logic         blk_last_o
);

  state_t                           state_q, state_d;
  logic [3:0]                       idx_q;
  logic [CNT_W-1:0]                 cnt_q;
  logic [BLK_WORDS-1:0][31:0]       blk_q;
  logic                             last_q, extra_q, x80_q;

  logic                             acc;
  logic                             full_word;
  logic [CNT_W-1:0]                 cnt_fin;
  logic [63:0]                      len_fin, len_cur;
  logic [4:0]                       p_idx;
  logic                             need_extra;
  logic [BLK_WORDS-1:0][31:0]       last_blk, extra_blk;

  assign acc = in_valid_i & in_ready_o;

  // Candidate block contents for the final data word and for the overflow block.
  always_comb begin
    full_word  = (in_bytes_i >= 3'd4);
    cnt_fin    = cnt_q + CNT_W'(in_bytes_i);
    len_fin    = 64'({cnt_fin, 3'b000});
    len_cur    = 64'({cnt_q, 3'b000});
    p_idx      = {1'b0, idx_q} + 5'(full_word);
    need_extra = (p_idx > 5'd13);

    last_blk = '0;
    for (int j = 0; j < BLK_WORDS; j++) begin
      if (j < int'(idx_q))
        last_blk[j] = blk_q[j];
      else if (j == int'(idx_q))
        last_blk[j] = sha1_pad_word(in_data_i, in_bytes_i);
      else if (full_word && (j == int'(idx_q) + 1))
        last_blk[j] = PAD_WORD;
    end
    if (!need_extra) begin
      last_blk[LEN_HI_IDX] = len_fin[63:32];
      last_blk[LEN_LO_IDX] = len_fin[31:0];
    end

    extra_blk             = '0;
    extra_blk[0]          = x80_q ? PAD_WORD : 32'h0;
    extra_blk[LEN_HI_IDX] = len_cur[63:32];
    extra_blk[LEN_LO_IDX] = len_cur[31:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (acc && (in_last_i || idx_q == 4'd15)) state_d = EMIT;
      EMIT:    if (blk_ready_i) state_d = extra_q ? EMIT_X : FILL;
      EMIT_X:  if (blk_ready_i) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_comb begin
    in_ready_o  = (state_q == FILL);
    blk_valid_o = (state_q == EMIT) || (state_q == EMIT_X);
    blk_data_o  = blk_q;
    blk_last_o  = last_q;
  end

  // Buffer, word index, byte counter and block flags.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      blk_q   <= '0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      x80_q   <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (acc) begin
            if (in_last_i) begin
              blk_q   <= last_blk;
              cnt_q   <= cnt_fin;
              idx_q   <= '0;
              last_q  <= !need_extra;
              extra_q <= need_extra;
              x80_q   <= full_word && (idx_q == 4'd15);
            end else begin
              blk_q[idx_q] <= in_data_i;
              cnt_q        <= cnt_q + CNT_W'(4);
              idx_q        <= idx_q + 4'd1;
            end
          end
        end
        EMIT: begin
          if (blk_ready_i) begin
            if (extra_q) begin
              blk_q  <= extra_blk;
              last_q <= 1'b1;
            end else begin
              blk_q  <= '0;
              idx_q  <= '0;
              last_q <= 1'b0;
              if (last_q) cnt_q <= '0;
            end
          end
        end
        EMIT_X: begin
          if (blk_ready_i) begin
            blk_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            extra_q <= 1'b0;
            x80_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_padder.sv
// Bench for sha1_padder: fixed vectors, hand-built corner sequences and random messages vs a byte-level model.
module tb_sha1_padder;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [31:0]  in_data_i;
  logic         in_last_i;
  logic [2:0]   in_bytes_i;
  logic         blk_valid_o;
  logic         blk_ready_i;
  logic [511:0] blk_data_o;
  logic         blk_last_o;

  sha1_padder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_bytes_i  (in_bytes_i),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_data_o  (blk_data_o),
    .blk_last_o  (blk_last_o)
  );

  always #5 clk_i = ~clk_i;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int          len;
    int          blocks;
    logic [31:0] w0_final;
    logic [31:0] w15_final;
  } vec_t;

  int n_pass  = 0;
  int n_total = 0;

  logic [511:0] got_d[$];
  logic         got_l[$];
  logic [511:0] exp_d[$];
  logic         exp_l[$];
  logic [511:0] abc_blk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit big-endian bit count.
  task automatic model(input bq_t msg);
    bq_t             p;
    longint unsigned bits;
    logic [511:0]    d;
    int              nb;
    p = msg;
    exp_d.delete();
    exp_l.delete();
    bits = longint'(msg.size()) * 8;
    p.push_back(8'h80);
    while ((p.size() % 64) != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(8'(bits >> (8 * i)));
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int k = 0; k < 16; k++)
        d[32*k +: 32] = {p[64*b+4*k], p[64*b+4*k+1], p[64*b+4*k+2], p[64*b+4*k+3]};
      exp_d.push_back(d);
      exp_l.push_back(b == nb - 1);
    end
  endtask

  task automatic run_msg(input bq_t msg, input int rdy_pct, input int vld_pct, output bit ok);
    int          n;
    int          nw;
    int          wi;
    int          cyc;
    bit          done;
    logic [31:0] w;
    n    = msg.size();
    nw   = (n == 0) ? 1 : (n + 3) / 4;
    wi   = 0;
    cyc  = 0;
    done = 1'b0;
    got_d.delete();
    got_l.delete();
    while (!done && cyc < 3000) begin
      @(negedge clk_i);
      cyc++;
      if (wi < nw && int'($urandom_range(99)) < vld_pct) begin
        w = $urandom;
        for (int j = 0; j < 4; j++)
          if (4 * wi + j < n) w[31-8*j -: 8] = msg[4*wi+j];
        in_valid_i = 1'b1;
        in_data_i  = w;
        in_last_i  = (wi == nw - 1);
        in_bytes_i = (wi == nw - 1) ? 3'(n - 4 * wi) : 3'($urandom);
      end else begin
        in_valid_i = 1'b0;
        in_data_i  = $urandom;
        in_last_i  = 1'($urandom);
        in_bytes_i = 3'($urandom);
      end
      blk_ready_i = int'($urandom_range(99)) < rdy_pct;
      #1;
      if (in_valid_i && in_ready_o) wi++;
      if (blk_valid_o && blk_ready_i) begin
        got_d.push_back(blk_data_o);
        got_l.push_back(blk_last_o);
        if (blk_last_o) done = 1'b1;
      end
    end
    ok = done;
  endtask

  task automatic check_msg(input string name, input bq_t msg, input int rdy_pct, input int vld_pct);
    bit ok;
    model(msg);
    run_msg(msg, rdy_pct, vld_pct, ok);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s_timeout: got no final block, required one within budget", name);
    check({name, "_nblk"}, 512'(got_d.size()), 512'(exp_d.size()));
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      check($sformatf("%s_blk%0d", name, i), got_d[i], exp_d[i]);
      check($sformatf("%s_last%0d", name, i), 512'(got_l[i]), 512'(exp_l[i]));
    end
  endtask

  initial begin
    vec_t tbl[6];
    bq_t  msg;
    bq_t  abc;
    logic [511:0] snap;

    tbl[0] = '{len: 0,  blocks: 1, w0_final: 32'h8000_0000, w15_final: 32'h0000_0000};
    tbl[1] = '{len: 3,  blocks: 1, w0_final: 32'h0102_0380, w15_final: 32'h0000_0018};
    tbl[2] = '{len: 4,  blocks: 1, w0_final: 32'h0102_0304, w15_final: 32'h0000_0020};
    tbl[3] = '{len: 55, blocks: 1, w0_final: 32'h0102_0304, w15_final: 32'h0000_01B8};
    tbl[4] = '{len: 56, blocks: 2, w0_final: 32'h0000_0000, w15_final: 32'h0000_01C0};
    tbl[5] = '{len: 64, blocks: 2, w0_final: 32'h8000_0000, w15_final: 32'h0000_0200};

    abc_blk          = '0;
    abc_blk[31:0]    = 32'h6162_6380;
    abc_blk[511:480] = 32'h0000_0018;
    abc = '{8'h61, 8'h62, 8'h63};

    rst_i       = 1'b1;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    in_last_i   = 1'b0;
    in_bytes_i  = '0;
    blk_ready_i = 1'b0;
    #1;
    check("rst_in_ready", 512'(in_ready_o), 512'(1));
    check("rst_blk_valid", 512'(blk_valid_o), 512'(0));
    check("rst_blk_last", 512'(blk_last_o), 512'(0));
    check("rst_blk_data", blk_data_o, '0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    foreach (tbl[t]) begin
      msg.delete();
      for (int i = 0; i < tbl[t].len; i++) msg.push_back(8'(i + 1));
      check_msg($sformatf("vec%0d", tbl[t].len), msg, 100, 100);
      check($sformatf("vec%0d_nblk_const", tbl[t].len), 512'(got_d.size()), 512'(tbl[t].blocks));
      if (got_d.size() > 0) begin
        check($sformatf("vec%0d_w0", tbl[t].len), 512'(got_d[got_d.size()-1][31:0]), 512'(tbl[t].w0_final));
        check($sformatf("vec%0d_w15", tbl[t].len), 512'(got_d[got_d.size()-1][511:480]), 512'(tbl[t].w15_final));
      end
    end

    check_msg("abc", abc, 100, 100);
    if (got_d.size() > 0) check("abc_const", got_d[0], abc_blk);

    // Backpressure: block held stable and input stalled while consumer is not ready.
    @(negedge clk_i);
    in_valid_i = 1'b1; in_data_i = 32'h6162_63AA; in_last_i = 1'b1; in_bytes_i = 3'd3;
    blk_ready_i = 1'b0;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    check("bp_latency_valid", 512'(blk_valid_o), 512'(1));
    check("bp_data", blk_data_o, abc_blk);
    snap = blk_data_o;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_i);
      check($sformatf("bp_stable%0d", c), blk_data_o, snap);
      check($sformatf("bp_in_ready%0d", c), 512'(in_ready_o), 512'(0));
    end
    blk_ready_i = 1'b1;
    @(negedge clk_i);
    blk_ready_i = 1'b0;
    check("bp_release_in_ready", 512'(in_ready_o), 512'(1));
    check("bp_release_valid", 512'(blk_valid_o), 512'(0));

    // Reset mid-message (7 words) and with a full block pending (16 words).
    foreach (tbl[t]) begin
      int nwords;
      if (t > 1) break;
      nwords = (t == 0) ? 7 : 16;
      for (int i = 0; i < nwords; i++) begin
        @(negedge clk_i);
        in_valid_i = 1'b1; in_data_i = $urandom; in_last_i = 1'b0; in_bytes_i = 3'd4;
      end
      @(negedge clk_i);
      in_valid_i = 1'b0;
      rst_i = 1'b1;
      #1;
      check($sformatf("mid_rst%0d_valid", nwords), 512'(blk_valid_o), 512'(0));
      check($sformatf("mid_rst%0d_in_ready", nwords), 512'(in_ready_o), 512'(1));
      check($sformatf("mid_rst%0d_data", nwords), blk_data_o, '0);
      @(negedge clk_i);
      rst_i = 1'b0;
      check_msg($sformatf("post_rst%0d_abc", nwords), abc, 100, 100);
      if (got_d.size() > 0) check($sformatf("post_rst%0d_abc_const", nwords), got_d[0], abc_blk);
    end

    for (int r = 0; r < 40; r++) begin
      int len;
      len = int'($urandom_range(200));
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom));
      check_msg($sformatf("rand%0d", r), msg, int'($urandom_range(100, 30)), int'($urandom_range(100, 50)));
    end

    @(negedge clk_i);
    in_valid_i  = 1'b0;
    blk_ready_i = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
